// File: rtl/r2r_dac_sequencer.sv
// r2r_dac_sequencer: update-rate sequencer for an 8-bit R2R DAC.
// A reloadable down-counter produces a sample tick. On each tick the DAC code
// is refreshed from the external data bus or from an internal generator.
// Optional build macro R2R_TRIANGLE_EN turns the internal ramp into a triangle
// wave (adds a direction register). The port list is identical in both builds.
module r2r_dac_sequencer #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_data,
  input  logic       load_divider,
  input  logic [7:0] data,
  output logic [7:0] r2r_out,
  output logic       tick
);

  localparam logic [DIV_W-1:0] DIV_RESET_V = DIV_W'(DIV_RESET);

  logic [DIV_W-1:0] reload_reg, reload_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic             load_prev_reg;
  logic [7:0]       code_reg, code_next;
  logic             tick_reg, tick_next;
  logic [7:0]       gen_code;
  logic             load_edge;

  // A held-high load_divider only acts on its first cycle.
  assign load_edge = load_divider & ~load_prev_reg;

`ifdef R2R_TRIANGLE_EN
  // dir_reg = 1 means the triangle is rising.
  logic dir_reg, dir_next, gen_dir;

  // Triangle generator: peaks 255 and 0 are emitted once, then direction flips.
  always_comb begin
    gen_dir  = dir_reg;
    gen_code = code_reg;
    if (ext_data) begin
      gen_code = data;
    end else if (dir_reg) begin
      if (code_reg == 8'hFF) begin
        gen_code = 8'hFE;
        gen_dir  = 1'b0;
      end else begin
        gen_code = code_reg + 8'd1;
      end
    end else begin
      if (code_reg == 8'h00) begin
        gen_code = 8'h01;
        gen_dir  = 1'b1;
      end else begin
        gen_code = code_reg - 8'd1;
      end
    end
  end
`else
  // Ramp generator: wraps 255 -> 0, continues from whatever code is showing.
  always_comb begin
    gen_code = ext_data ? data : code_reg + 8'd1;
  end
`endif

  // Divider and code update: load edge beats a due tick, which beats counting.
  always_comb begin
    reload_next = reload_reg;
    cnt_next    = cnt_reg;
    code_next   = code_reg;
    tick_next   = 1'b0;
`ifdef R2R_TRIANGLE_EN
    dir_next    = dir_reg;
`endif
    if (load_edge) begin
      reload_next = DIV_W'(data);
      cnt_next    = DIV_W'(data);
    end else if (cnt_reg == '0) begin
      cnt_next  = reload_reg;
      tick_next = 1'b1;
      code_next = gen_code;
`ifdef R2R_TRIANGLE_EN
      dir_next  = gen_dir;
`endif
    end else begin
      cnt_next = cnt_reg - DIV_W'(1);
    end
  end

  // State registers; rst restores the power-on divider and clears the code.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_reg    <= DIV_RESET_V;
      cnt_reg       <= DIV_RESET_V;
      load_prev_reg <= 1'b0;
      code_reg      <= 8'h00;
      tick_reg      <= 1'b0;
`ifdef R2R_TRIANGLE_EN
      dir_reg       <= 1'b1;
`endif
    end else begin
      reload_reg    <= reload_next;
      cnt_reg       <= cnt_next;
      load_prev_reg <= load_divider;
      code_reg      <= code_next;
      tick_reg      <= tick_next;
`ifdef R2R_TRIANGLE_EN
      dir_reg       <= dir_next;
`endif
    end
  end

  assign r2r_out = code_reg;
  assign tick    = tick_reg;

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Testbench for r2r_dac_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a period/phase reference model.
module tb_r2r_dac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_data = 1'b0;
  logic       load_divider = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] r2r_out;
  logic       tick;

  int total = 0;
  int bad   = 0;

  // Reference model: period in clocks and clocks elapsed since period start.
  int m_period = 10;
  int m_since  = 0;
  int m_code   = 0;
  int m_tick   = 0;
  int m_lprev  = 0;
  int m_up     = 1;

  r2r_dac_sequencer #(.DIV_W(8), .DIV_RESET(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_data     (ext_data),
    .load_divider (load_divider),
    .data         (data),
    .r2r_out      (r2r_out),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  function automatic int gen_next(input int code, input int ext, input int d);
    if (ext != 0) return d;
`ifdef R2R_TRIANGLE_EN
    if (m_up != 0) begin
      if (code == 255) begin m_up = 0; return 254; end
      return code + 1;
    end
    if (code == 0) begin m_up = 1; return 1; end
    return code - 1;
`else
    return (code + 1) % 256;
`endif
  endfunction

  task automatic step(input logic r, input logic e, input logic ld, input logic [7:0] d);
    logic [7:0] exp_code;
    logic       exp_tick;
    rst = r; ext_data = e; load_divider = ld; data = d;
    @(posedge clk);
    if (r) begin
      m_period = 10; m_since = 0; m_code = 0; m_tick = 0; m_lprev = 0; m_up = 1;
    end else begin
      if (ld && m_lprev == 0) begin
        m_period = int'(d) + 1;
        m_since  = 0;
        m_tick   = 0;
      end else begin
        m_since = m_since + 1;
        if (m_since >= m_period) begin
          m_since = 0;
          m_tick  = 1;
          m_code  = gen_next(m_code, int'(e), int'(d));
        end else begin
          m_tick = 0;
        end
      end
      m_lprev = int'(ld);
    end
    #1;
    exp_code = 8'(m_code);
    exp_tick = (m_tick != 0);
    total++;
    assert (r2r_out === exp_code)
      else begin bad++; $error("FAIL r2r_out t=%0t got=%0d want=%0d", $time, r2r_out, exp_code); end
    total++;
    assert (tick === exp_tick)
      else begin bad++; $error("FAIL tick t=%0t got=%0b want=%0b", $time, tick, exp_tick); end
    $display("step t=%0t rst=%0b ext=%0b ld=%0b data=%0d -> r2r_out=%0d tick=%0b",
             $time, r, e, ld, d, r2r_out, tick);
  endtask

  initial begin
    int guard;
    // Reset for two cycles, then default 10-clock ramp.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));

    // Load divider 3 -> period 4, then 0 -> tick every cycle.
    step(1'b0, 1'b0, 1'b1, 8'd3);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));

    // External data with reload 4, data changing every clock.
    step(1'b0, 1'b1, 1'b1, 8'd4);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b0, 8'($urandom));

    // Wrap through 255 at one tick per clock, starting from code 254.
    step(1'b0, 1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd254);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    // Approach zero from above (triangle turns around at 0).
    step(1'b0, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));

    // Collision: load edge exactly when the counter is due to tick.
    step(1'b0, 1'b0, 1'b1, 8'd5);
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    guard = 0;
    while (m_since != m_period - 1 && guard < 300) begin
      step(1'b0, 1'b0, 1'b0, 8'($urandom));
      guard++;
    end
    total++;
    assert (guard < 300)
      else begin bad++; $error("FAIL collision_setup got=%0d want<300", guard); end
    step(1'b0, 1'b0, 1'b1, 8'd6);
    // Hold load high 20 cycles in total: only the first cycle loads.
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 3)));
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));

    // Reset mid-operation: reload 2, ramp around code 100.
    step(1'b0, 1'b0, 1'b1, 8'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'd100);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic r, e, ld;
      logic [7:0] d;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 14) == 0);
      e  = ($urandom_range(0, 2) == 0);
      d  = ld ? 8'($urandom_range(0, 6)) : 8'($urandom);
      step(r, e, ld, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
